// File: rtl/shifter_right_seq.sv
`default_nettype none
// ============================================================================
//  Module   : shifter_right_seq
//  Purpose  : Multi-cycle 32-bit right shifter (SRL/SRA), one log stage per
//             clock in the order 16, 8, 4, 2, 1, with start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module shifter_right_seq #(
    parameter logic [2:0] SRL = 3'b100,
    parameter logic [2:0] SRA = 3'b101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [2:0]  Signal,
    output logic        busy,
    output logic        done,
    output logic [31:0] dataOut
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [31:0] r_work;
    logic [4:0]  r_amt;
    logic [2:0]  r_mode;
    logic [31:0] r_dout;

    logic        w_accept;
    logic        w_last;
    logic        w_mode_ok;
    logic        w_do_shift;
    logic [15:0] w_fill;
    logic [31:0] w_shifted;
    logic [31:0] w_work_nxt;
    logic        w_unused;

    // Only the low five bits of the amount matter.
    assign w_unused  = ^dataB[31:5];

    assign w_accept  = start && (r_state != ST_SHIFT);
    assign w_last    = (r_cnt == 3'd4);
    assign w_mode_ok = (r_mode == SRL) || (r_mode == SRA);
    assign w_fill    = {16{r_work[31] & (r_mode == SRA)}};
    assign dataOut   = r_dout;

    // Stage k moves the word by 16>>k when amount bit (4-k) is set.
    always_comb begin
        w_do_shift = 1'b0;
        w_shifted  = r_work;
        case (r_cnt)
            3'd0: begin
                w_do_shift = r_amt[4];
                w_shifted  = {w_fill[15:0], r_work[31:16]};
            end
            3'd1: begin
                w_do_shift = r_amt[3];
                w_shifted  = {w_fill[7:0], r_work[31:8]};
            end
            3'd2: begin
                w_do_shift = r_amt[2];
                w_shifted  = {w_fill[3:0], r_work[31:4]};
            end
            3'd3: begin
                w_do_shift = r_amt[1];
                w_shifted  = {w_fill[1:0], r_work[31:2]};
            end
            default: begin
                w_do_shift = r_amt[0];
                w_shifted  = {w_fill[0], r_work[31:1]};
            end
        endcase
        w_work_nxt = w_do_shift ? w_shifted : r_work;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? ST_SHIFT : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_work  <= 32'h0;
            r_amt   <= 5'd0;
            r_mode  <= 3'd0;
            r_dout  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_work <= dataA;
                r_amt  <= dataB[4:0];
                r_mode <= Signal;
                r_cnt  <= 3'd0;
            end else if (r_state == ST_SHIFT) begin
                r_work <= w_work_nxt;
                r_cnt  <= r_cnt + 3'd1;
                if (w_last) r_dout <= w_mode_ok ? w_work_nxt : 32'h0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shifter_right_seq.sv
`default_nettype none
// Scoreboard bench for shifter_right_seq: driver pushes reference results,
// negedge monitor checks busy/done/dataOut against the queue every cycle.
module tb_shifter_right_seq;

    localparam logic [2:0] C_SRL = 3'b100;
    localparam logic [2:0] C_SRA = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [2:0]  Signal;
    logic        busy;
    logic        done;
    logic [31:0] dataOut;

    typedef struct {
        logic [31:0] data;
        int          due;
    } item_t;

    item_t       q[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_exp = 32'h0;
    logic        mon_en = 1'b0;

    shifter_right_seq #(.SRL(C_SRL), .SRA(C_SRA)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] n,
                                          input logic [2:0] s);
        if (s == C_SRL) return a >> n;
        if (s == C_SRA) return 32'($signed(a) >>> n);
        return 32'h0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: the pending op at the queue head defines busy/done timing.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_busy;
            logic exp_done;
            exp_busy = (q.size() > 0) && (cyc >= q[0].due - 5) && (cyc < q[0].due);
            exp_done = (q.size() > 0) && (cyc == q[0].due);
            check("busy", {31'b0, busy}, {31'b0, exp_busy});
            check("done", {31'b0, done}, {31'b0, exp_done});
            if (exp_done) begin
                last_exp = q[0].data;
                void'(q.pop_front());
            end
            check("dataOut", dataOut, last_exp);
            if (q.size() > 0 && cyc > q[0].due) void'(q.pop_front());
        end
    end

    task automatic slot();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
        slot();
        start  = 1'b1;
        dataA  = a;
        dataB  = b;
        Signal = s;
        q.push_back('{data: model(a, b[4:0], s), due: cyc + 6});
    endtask

    // After issue, five SHIFT slots follow; the next issue lands in the DONE slot.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                          input bit garbage, input bit chain);
        issue(a, b, s);
        repeat (5) begin
            slot();
            start = garbage;
            if (garbage) begin
                dataA  = $urandom;
                dataB  = $urandom;
                Signal = 3'($urandom);
            end
        end
        if (!chain) begin
            slot();
            start = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        slot();
        rst      = 1'b1;
        start    = 1'b0;
        q.delete();
        last_exp = 32'h0;
        repeat (n - 1) slot();
        slot();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        dataA  = 32'h0;
        dataB  = 32'h0;
        Signal = 3'b000;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;
        do_reset(2);
        repeat (6) slot();

        run_op(32'h8000_0000, 32'd31,        C_SRL,  1'b0, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0024, C_SRA,  1'b0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'd31,        C_SRA,  1'b0, 1'b0);
        run_op(32'hDEAD_BEEF, 32'd0,         C_SRL,  1'b0, 1'b0);
        run_op(32'h1234_5678, 32'd3,         3'b011, 1'b0, 1'b0);
        run_op(32'hF0F0_1234, 32'd7,         C_SRA,  1'b1, 1'b1);
        run_op(32'h8765_4321, 32'd12,        C_SRL,  1'b1, 1'b0);

        // Reset during the third SHIFT cycle discards the operation.
        issue(32'hCAFE_F00D, 32'd9, C_SRA);
        slot();
        start = 1'b0;
        slot();
        do_reset(1);
        repeat (8) slot();
        run_op(32'hCAFE_F00D, 32'd9, C_SRA, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            logic [2:0] s;
            case ($urandom_range(0, 4))
                0, 1:    s = C_SRL;
                2, 3:    s = C_SRA;
                default: s = 3'($urandom);
            endcase
            run_op($urandom, $urandom, s, 1'($urandom), 1'($urandom));
        end

        slot();
        start = 1'b0;
        repeat (10) slot();
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
